// File: rtl/instr_sequencer_pkg.sv
// instr_sequencer_pkg: state encoding, instruction field positions and opcode constants
package instr_sequencer_pkg;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_READ_A = 3'd2,
    ST_READ_B = 3'd3,
    ST_EXEC   = 3'd4,
    ST_WB     = 3'd5
  } state_t;
  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 27;
  localparam int RD_MSB  = 26;
  localparam int RS1_MSB = 21;
  localparam int RS2_MSB = 16;
  localparam logic [4:0] OPC_NOP = 5'd0;
endpackage

// File: rtl/instr_sequencer_exec.sv
// exec_timer: counts EXEC cycles from 1 and flags when EXEC_TIMEOUT is reached
module exec_timer #(
  parameter int EXEC_TIMEOUT = 15,
  parameter int CW = $clog2(EXEC_TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          expired
);
  assign expired = count == CW'(EXEC_TIMEOUT);
  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else count <= clear ? CW'(1) : (enable && !expired) ? count + CW'(1) : count;
  end
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle DECODE/READ_A/READ_B/EXEC/WB control stage driving decoder and bus enables
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int DW = 32,
  parameter int OPW = 5,
  parameter int EXEC_TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           instr_valid,
  output logic           instr_ready,
  input  logic [DW-1:0]  instr,
  input  logic           exec_done,
  output logic [OPW-1:0] opcode,
  output logic           dec_enable,
  output logic [4:0]     rd_addr,
  output logic [4:0]     rs1_addr,
  output logic [4:0]     rs2_addr,
  output logic           oe_a,
  output logic           oe_b,
  output logic           oe_res,
  output logic           wb_en,
  output logic           busy,
  output logic           err_timeout
);
  state_t state, state_n;
  logic accept, expired;
  assign instr_ready = state == ST_IDLE && !rst;
  assign accept      = instr_valid && instr_ready;
  assign dec_enable  = state == ST_DECODE || state == ST_EXEC;
  assign oe_a        = state == ST_READ_A;
  assign oe_b        = state == ST_READ_B;
  assign oe_res      = state == ST_WB;
  assign wb_en       = state == ST_WB;
  assign busy        = state != ST_IDLE;
  exec_timer #(.EXEC_TIMEOUT(EXEC_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == ST_READ_B),
    .enable  (state == ST_EXEC),
    .count   (),
    .expired (expired)
  );
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   state_n = accept ? ST_DECODE : ST_IDLE;
      ST_DECODE: state_n = opcode == OPW'(OPC_NOP) ? ST_IDLE : ST_READ_A;
      ST_READ_A: state_n = ST_READ_B;
      ST_READ_B: state_n = ST_EXEC;
      ST_EXEC:   state_n = exec_done ? ST_WB : expired ? ST_IDLE : ST_EXEC;
      default:   state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      opcode      <= '0;
      rd_addr     <= '0;
      rs1_addr    <= '0;
      rs2_addr    <= '0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        opcode   <= instr[OP_MSB:OP_LSB];
        rd_addr  <= instr[RD_MSB-:5];
        rs1_addr <= instr[RS1_MSB-:5];
        rs2_addr <= instr[RS2_MSB-:5];
      end
      err_timeout <= accept ? 1'b0 : (state == ST_EXEC && !exec_done && expired) ? 1'b1 : err_timeout;
    end
  end
endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle control stage that sits directly upstream of the opcode decoder and the 32-bit tri-state bus drivers.
- Accepts one 32-bit instruction per handshake and latches its opcode and register fields.
- Sequences DECODE / READ_A / READ_B / EXEC / WB phases, driving the decoder enable, the opcode, and the one-hot tri-state output enables for operand-A, operand-B and result drivers onto the shared bus.

Parameters:
DW, 32, instruction word width (fixed field layout below assumes 32)
OPW, 5, opcode width; feeds the 5-to-32 decoder
EXEC_TIMEOUT, 15, maximum EXEC cycles waiting for exec_done (must be >= 1)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
instr_valid  input  1  upstream offers instr this cycle
instr_ready  output  1  sequencer can accept an instruction
instr  input  DW  instruction: [31:27] opcode, [26:22] rd, [21:17] rs1, [16:12] rs2, [11:0] ignored
exec_done  input  1  execution unit finished current op
opcode  output  OPW  latched opcode to decoder
dec_enable  output  1  decoder enable
rd_addr  output  5  latched rd
rs1_addr  output  5  latched rs1
rs2_addr  output  5  latched rs2
oe_a  output  1  tri-state enable, operand-A driver
oe_b  output  1  tri-state enable, operand-B driver
oe_res  output  1  tri-state enable, result driver
wb_en  output  1  register-file write strobe for rd
busy  output  1  high in any state other than IDLE
err_timeout  output  1  sticky EXEC timeout flag

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- rst has priority over every other input.
- States: IDLE, DECODE, READ_A, READ_B, EXEC, WB.
- Reset:
  - state=IDLE; opcode/rd/rs1/rs2 latches=0; exec counter=0; err_timeout=0.
  - dec_enable, oe_a, oe_b, oe_res, wb_en, busy all 0.
  - instr_ready = (state==IDLE) && !rst, so it is 0 while rst is high.
- Control outputs are Moore decodes of the state register only:
  - dec_enable=1 in DECODE and EXEC.
  - oe_a=1 in READ_A only; oe_b=1 in READ_B only.
  - oe_res=1 and wb_en=1 in WB only.
  - At most one oe_* is high in any cycle.
- IDLE:
  - instr_valid && instr_ready: latch fields, clear err_timeout, go to DECODE.
  - Otherwise stay in IDLE.
- DECODE: 1 cycle. Latched opcode==0 (NOP) -> IDLE; otherwise -> READ_A.
- READ_A -> READ_B -> EXEC, 1 cycle each, unconditional.
- EXEC:
  - Counter starts at 1 on entry and increments each further EXEC cycle.
  - exec_done=1 -> WB.
  - exec_done=0 with counter==EXEC_TIMEOUT -> set err_timeout, go to IDLE, skip WB.
  - exec_done and timeout in the same cycle: done wins, go to WB, no error.
- WB: 1 cycle -> IDLE.
- Latency, accept at edge N with exec_done in the first EXEC cycle:
  - DECODE N+1, READ_A N+2, READ_B N+3, EXEC N+4, WB N+5.
  - instr_ready high again at N+6.
- NOP: DECODE at N+1, ready at N+2.
- instr_valid outside IDLE is ignored; instr is not sampled.
- exec_done outside EXEC is ignored.
- Latched fields hold their values until the next accept.
- Counter width is clog2(EXEC_TIMEOUT+1); it never wraps because it is reset on every EXEC entry.
- Reset mid-operation (any state): IDLE at the next edge, all oe_* and wb_en low, no partial writeback.
- err_timeout stays high until rst or the next accepted instruction.

Decomposition:
- Shared package holds:
  - state encoding constants: ST_IDLE..ST_WB, 3-bit binary.
  - field bit positions: OP_MSB=31, OP_LSB=27, RD_MSB=26, RS1_MSB=21, RS2_MSB=16.
  - OPC_NOP=5'd0.
- One sub-module is natural: exec_timer.
  - Inputs: clear/enable.
  - Outputs: count, expired at EXEC_TIMEOUT.
  - Parameterised by EXEC_TIMEOUT.

Test Plan:
1. Reset: rst=1 for 2 cycles mid-stream -> all outputs 0 and instr_ready=0 while rst=1; instr_ready=1 on the first cycle after rst falls.
2. instr=0x28C22000 (op 5, rd 3, rs1 1, rs2 2), exec_done=1 in first EXEC cycle -> opcode=5, rd/rs1/rs2=3/1/2; dec_enable at N+1 and N+4; oe_a N+2; oe_b N+3; oe_res=wb_en=1 at N+5; ready at N+6.
3. NOP instr=0x00000000 -> dec_enable at N+1 only; no oe_*/wb_en pulses; instr_ready=1 at N+2.
4. EXEC_TIMEOUT=4, op 7, exec_done held 0 -> exactly 4 EXEC cycles, then err_timeout=1, no wb_en, IDLE. Next accept clears err_timeout. Separate run with exec_done=1 on the 4th EXEC cycle -> WB, err_timeout=0.
5. rst asserted during EXEC -> IDLE next edge; wb_en and oe_res never pulse; latches=0.
6. instr_valid held high with 3 different instructions back-to-back -> each accepted only when instr_ready=1; checker confirms oe_a+oe_b+oe_res<=1 every cycle and no instr sampled while busy=1.
